// File: rtl/bcx_pkg.sv
// Shared definitions for the SHA result-checker slice: bus widths, the
// default nonce width and the checker FSM state encoding.
package bcx_pkg;

  localparam int unsigned HASH_W      = 256;
  localparam int unsigned DIFF_W      = 32;
  localparam int unsigned NONCE_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_REPORT = 2'd2,
    ST_DONE   = 2'd3
  } checker_state_t;

endpackage

// File: rtl/eff.sv
// Generic enabled flop with synchronous active-low reset.
// Ports:
//   clk - clock
//   rst - synchronous reset, active low
//   en  - load enable
//   d   - next value
//   q   - registered value
module eff #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sha_result_checker_compact_target.sv
// Expands a compact difficulty word (exponent [31:24], mantissa [23:0])
// into the full 256-bit target. Purely combinational.
// Ports:
//   i_difficulty - compact target word
//   o_target_c   - expanded 256-bit target
module compact_target
  import bcx_pkg::*;
(
  input  logic [DIFF_W-1:0] i_difficulty,
  output logic [HASH_W-1:0] o_target_c
);

  logic [7:0]        w_exp;
  logic [HASH_W-1:0] w_mant;
  logic [4:0]        w_bytes;

  // Exponent counts bytes; the mantissa sits at exponent 3.
  always_comb begin
    w_exp      = i_difficulty[DIFF_W-1 -: 8];
    w_mant     = HASH_W'(i_difficulty[23:0]);
    w_bytes    = '0;
    o_target_c = '1;
    if (w_exp > 8'd32) begin
      o_target_c = '1;
    end else if (w_exp <= 8'd3) begin
      w_bytes    = 5'(8'd3 - w_exp);
      o_target_c = w_mant >> {w_bytes, 3'b000};
    end else begin
      w_bytes    = 5'(w_exp - 8'd3);
      o_target_c = w_mant << {w_bytes, 3'b000};
    end
  end

endmodule

// File: rtl/sha_result_checker.sv
// Consumer of the SHA core's per-nonce hash stream. Numbers each valid
// hash, compares it against the expanded difficulty target and reports the
// first winning nonce (or block exhaustion) through a valid/ready port.
// Ports:
//   clk, rst              - clock, synchronous active-low reset
//   validIn, newBlockIn   - input hash valid / first hash of a new block
//   hash, difficulty      - hash value and compact target
//   resultValid/Ready     - result handshake
//   resultFound           - 1 winning nonce, 0 block exhausted
//   resultNonce/Hash      - reported nonce and its hash
//   overrun               - sticky: input arrived while a result was held
module sha_result_checker
  import bcx_pkg::*;
#(
  parameter int unsigned NONCE_W = NONCE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               validIn,
  input  logic               newBlockIn,
  input  logic [HASH_W-1:0]  hash,
  input  logic [DIFF_W-1:0]  difficulty,
  output logic               resultValid,
  input  logic               resultReady,
  output logic               resultFound,
  output logic [NONCE_W-1:0] resultNonce,
  output logic [HASH_W-1:0]  resultHash,
  output logic               overrun
);

  localparam int unsigned S1_W = 1 + HASH_W + HASH_W + NONCE_W;
  localparam int unsigned S2_W = 1 + 1 + HASH_W + NONCE_W;

  checker_state_t     r_state, w_state_nxt;
  logic [NONCE_W-1:0] r_nonce_cnt, w_in_nonce;
  logic [HASH_W-1:0]  w_target;
  logic               w_flush, w_to_report, w_eval;

  logic               r_s1_v, r_s2_v;
  logic [S1_W-1:0]    r_s1_q;
  logic [S2_W-1:0]    r_s2_q;
  logic               w_s1_nb, w_s1_win, w_s2_nb, w_s2_win;
  logic [HASH_W-1:0]  w_s1_hash, w_s1_target, w_s2_hash;
  logic [NONCE_W-1:0] w_s1_nonce, w_s2_nonce;

  logic               r_valid, r_found, r_overrun;
  logic [NONCE_W-1:0] r_rnonce;
  logic [HASH_W-1:0]  r_rhash;
  logic               w_valid_nxt, w_found_nxt, w_overrun_nxt;
  logic [NONCE_W-1:0] w_rnonce_nxt;
  logic [HASH_W-1:0]  w_rhash_nxt;

  compact_target u_target (
    .i_difficulty (difficulty),
    .o_target_c   (w_target)
  );

  // Nonce numbering: a newBlock hash is nonce 0, later valid hashes count up.
  assign w_in_nonce = newBlockIn ? '0 : r_nonce_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_nonce_cnt <= '0;
    end else if (validIn) begin
      r_nonce_cnt <= w_in_nonce + NONCE_W'(1);
    end
  end

  // While a result is held (or about to be), the pipeline is emptied and
  // new inputs are refused so nothing stale survives into the next block.
  assign w_flush = (r_state == ST_REPORT) || w_to_report;

  // Stage 1: register hash, expanded target, nonce and flags.
  eff #(.W(1)) u_s1_v (
    .clk (clk), .rst (rst), .en (1'b1),
    .d   (validIn & ~w_flush), .q (r_s1_v)
  );
  eff #(.W(S1_W)) u_s1_d (
    .clk (clk), .rst (rst), .en (1'b1),
    .d   ({newBlockIn, hash, w_target, w_in_nonce}), .q (r_s1_q)
  );
  assign {w_s1_nb, w_s1_hash, w_s1_target, w_s1_nonce} = r_s1_q;
  assign w_s1_win = (w_s1_hash <= w_s1_target);

  // Stage 2: register the compare outcome for the FSM.
  eff #(.W(1)) u_s2_v (
    .clk (clk), .rst (rst), .en (1'b1),
    .d   (r_s1_v & ~w_flush), .q (r_s2_v)
  );
  eff #(.W(S2_W)) u_s2_d (
    .clk (clk), .rst (rst), .en (1'b1),
    .d   ({w_s1_nb, w_s1_win, w_s1_hash, w_s1_nonce}), .q (r_s2_q)
  );
  assign {w_s2_nb, w_s2_win, w_s2_hash, w_s2_nonce} = r_s2_q;

  // Anything in flight or arriving while the result is held is lost.
  assign w_overrun_nxt = r_overrun | (w_flush & (validIn | r_s1_v));

  // State and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_found   <= 1'b0;
      r_rnonce  <= '0;
      r_rhash   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_found   <= w_found_nxt;
      r_rnonce  <= w_rnonce_nxt;
      r_rhash   <= w_rhash_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Next-state and result capture.
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_valid;
    w_found_nxt  = r_found;
    w_rnonce_nxt = r_rnonce;
    w_rhash_nxt  = r_rhash;
    w_to_report  = 1'b0;
    w_eval       = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: w_eval = r_s2_v & w_s2_nb;
      ST_SEARCH:        w_eval = r_s2_v;
      ST_REPORT: begin
        if (resultReady) begin
          w_state_nxt = ST_DONE;
          w_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_eval) begin
      w_state_nxt = ST_SEARCH;
      if (w_s2_win || (w_s2_nonce == '1)) begin
        w_to_report  = 1'b1;
        w_state_nxt  = ST_REPORT;
        w_valid_nxt  = 1'b1;
        w_found_nxt  = w_s2_win;
        w_rnonce_nxt = w_s2_nonce;
        w_rhash_nxt  = w_s2_hash;
      end
    end
  end

  assign resultValid = r_valid;
  assign resultFound = r_found;
  assign resultNonce = r_rnonce;
  assign resultHash  = r_rhash;
  assign overrun     = r_overrun;

endmodule

// File: doc/sha_result_checker.md
# sha_result_checker

Consumer end of the SHA core's output stream. Takes the per-nonce `hash`/`difficulty` stream (`validIn`, `newBlockIn`), numbers each valid hash with a nonce index, and compares the hash against the 256-bit target expanded from the compact difficulty word. It reports the first winning nonce of each block, or block exhaustion, to the host through a valid/ready result port.

## Interface
- `NONCE_W`, 32: nonce counter width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset. One clock; reset is synchronous and active-low.
- `validIn`  in  1: `hash`/`difficulty` valid this cycle.
- `newBlockIn`  in  1: qualified by `validIn`; this hash is nonce 0 of a new block.
- `hash`  in  256: hash value, unsigned, bit 255 is the MSB.
- `difficulty`  in  32: compact target, exponent `[31:24]`, mantissa `[23:0]`, unsigned.
- `resultValid`  out  1: result held for the host.
- `resultReady`  in  1: host accepts the result when `resultValid && resultReady`.
- `resultFound`  out  1: 1 means winning nonce; 0 means block exhausted.
- `resultNonce`  out  NONCE_W: winning nonce, or all-ones on exhaustion.
- `resultHash`  out  256: hash of the reported nonce.
- `overrun`  out  1: sticky; an input arrived while `REPORT` was held. Cleared only by reset.

## Operation
- Target: exp ≤ 3 gives `mantissa >> 8*(3-exp)`. 4 ≤ exp ≤ 32 gives `mantissa << 8*(exp-3)`, truncated to 256 bits. exp > 32 gives all-ones.
- Win condition: `hash <= target`, 256-bit unsigned compare.
- Nonce index:
  - `validIn && newBlockIn` loads 0.
  - Each later `validIn` in the block increments it.
  - No increment without `validIn`.
- FSM states: `IDLE`, `SEARCH`, `REPORT`, `DONE`.
  - `IDLE`: entered on reset. Ignores hashes without `newBlockIn`. A valid newBlock hash goes to `SEARCH`, and that hash is evaluated.
  - `SEARCH`: each evaluated hash is classified.
    - Win: capture nonce and hash, `resultFound=1`, go to `REPORT`.
    - Non-win at nonce all-ones: capture, `resultFound=0`, `resultNonce=all-ones`, go to `REPORT`.
    - A newBlock hash in `SEARCH` restarts numbering at 0. The abandoned block is not reported.
  - `REPORT`: `resultValid=1`; outputs stable until the handshake. Every input with `validIn` is dropped and sets `overrun`, including newBlock hashes. Handshake goes to `DONE`.
  - `DONE`: ignores non-newBlock hashes. A valid newBlock hash goes to `SEARCH`, and that hash is evaluated.
- One result per block, at most.
- Reset mid-operation discards any pending result and clears the nonce, the pipeline and `overrun`.

## Timing
- 2-stage pipeline. Stage 1 registers `hash`, expanded target, nonce, valid and newBlock. Stage 2 compares and updates the FSM.
- Winning input sampled at edge N produces `resultValid=1` after edge N+2.
- Throughput: one hash per cycle in `SEARCH`.
- The `REPORT` drop check applies at pipeline input. A hash already in stage 1 when `REPORT` is entered is dropped and sets `overrun`.
- Handshake and a simultaneous incoming hash at the same edge: the handshake completes (go to `DONE`). The incoming hash is still dropped and flagged.
- `resultReady` high without `resultValid` has no effect.
- Reset values:
  - `resultValid=0`, `resultFound=0`, `resultNonce=0`, `resultHash=0`, `overrun=0`.
  - Pipeline valid bits 0; state `IDLE`.

## Structure
- Shared package `bcx_pkg`: `HASH_W=256`, `DIFF_W=32`, `NONCE_W` default, the `checker_state_t` enum.
- Sub-module `compact_target` (combinational, `difficulty` to 256-bit target). It is instantiated before the stage-1 register and unit-tested alone.
- Pipeline registers use the existing `eff` flop with enable tied high.

## Test plan
- Difficulty `0x1D00FFFF` (target `0xFFFF<<208`), newBlock then hashes {target+1, target+1, target}. Required: result after edge N+2 of the third hash, found=1, nonce=2.
- Same block, `resultReady` held low 5 cycles while 3 more hashes arrive. Required: outputs stable; `overrun=1`; a single result at handshake; state `DONE`.
- `NONCE_W=4`, no winners, 16 hashes. Required: found=0, nonce=`0xF`.
- Difficulty `0x22000001`: any hash wins at nonce 0. Difficulty `0x02FFFFFF`: target `0xFFFF`, so hash `0x10000` loses and hash `0xFFFF` wins.
- newBlock in `SEARCH` after nonce 7, then a win on the 2nd hash. Required: nonce=1.
- Reset (`rst=0`) asserted one cycle while in `REPORT`. Required: every output at its reset value on the next cycle; `IDLE` ignores hashes until a newBlock hash.
